// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the byte-enable and load-extension helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } lsu_state_t;

  // Byte-lane enables for a store of the given width at byte offset off.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] funct3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'h0, b};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_load_align.sv
// Combinational extraction and sign/zero extension of a dmem read word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  assign o_data = load_ext(i_funct3, i_off, i_word);

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Single-outstanding RV32I load/store controller in front of a synchronous dmem
// with fixed read latency; returns one response pulse per accepted request.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int          MEM_ADDR_WIDTH = 12,
  parameter logic [31:0] DMEM_BASE      = 32'h0000_0000,
  parameter int          RD_LATENCY     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_misalign,
  output logic        o_rsp_fault,
  output logic [31:0] o_data_addr,
  output logic [31:0] o_data_wr_data,
  output logic [3:0]  o_data_size,
  output logic        o_data_write,
  output logic        o_data_read,
  input  logic [31:0] i_data_rd_data
);

  localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

  lsu_state_t  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        fault_q, fault_d;

  logic        accept, illegal, misalign, out_of_win, fault, err;
  logic        do_store, do_load;
  logic [31:0] load_word;
  logic [31:0] store_data;

  // Request decode. Unknown funct3 and unsigned stores are reported as faults.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before the case,
    // otherwise unassigned paths infer latches.
    illegal  = 1'b0;
    misalign = 1'b0;
    case (i_req_funct3)
      F3_B:    ;
      F3_H:    misalign = i_req_addr[0];
      F3_W:    misalign = |i_req_addr[1:0];
      F3_BU:   illegal  = i_req_we;
      F3_HU: begin
        illegal  = i_req_we;
        misalign = i_req_addr[0];
      end
      default: illegal  = 1'b1;
    endcase
  end

  assign out_of_win = i_req_addr[31:MEM_ADDR_WIDTH] != DMEM_BASE[31:MEM_ADDR_WIDTH];
  assign fault      = ~misalign & (illegal | out_of_win);
  assign err        = misalign | fault;

  assign o_req_ready = (state_q == IDLE);
  assign accept      = i_req_valid & o_req_ready;
  assign do_store    = accept & ~err & i_req_we;
  assign do_load     = accept & ~err & ~i_req_we;

  always_comb begin
    case (i_req_funct3[1:0])
      2'b00:   store_data = {4{i_req_wdata[7:0]}};
      2'b01:   store_data = {2{i_req_wdata[15:0]}};
      default: store_data = i_req_wdata;
    endcase
  end

  // The dmem port is driven straight from the request in the acceptance cycle.
  assign o_data_write   = do_store;
  assign o_data_read    = do_load;
  assign o_data_addr    = (do_store | do_load) ? {i_req_addr[31:2], 2'b00} : 32'h0;
  assign o_data_wr_data = do_store ? store_data : 32'h0;
  assign o_data_size    = do_store ? be_gen(i_req_funct3, i_req_addr[1:0]) :
                          do_load  ? 4'b1111 : 4'b0000;

  lsu_load_align u_load_align (
    .i_funct3 (f3_q),
    .i_off    (off_q),
    .i_word   (i_data_rd_data),
    .o_data   (load_word)
  );

  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    fault_d    = fault_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d       = i_req_funct3;
          off_d      = i_req_addr[1:0];
          cnt_d      = WAIT_INIT;
          rdata_d    = 32'h0;
          misalign_d = misalign;
          fault_d    = fault;
          state_d    = do_load ? RD_WAIT : RESP;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = load_word;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      cnt_q      <= 2'b00;
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
    end
  end

  // Response fields are only visible during the RESP pulse.
  assign o_rsp_valid    = (state_q == RESP);
  assign o_rsp_rdata    = o_rsp_valid ? rdata_q : 32'h0;
  assign o_rsp_misalign = o_rsp_valid & misalign_q;
  assign o_rsp_fault    = o_rsp_valid & fault_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Randomized self-checking bench: two controllers (read latency 1 and 3) against
// a byte-level memory reference model.
module tb_lsu_dmem_ctrl;

  localparam int WIN = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid, use3, req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic        v1, v3;
  assign v1 = req_valid & ~use3;
  assign v3 = req_valid & use3;

  logic        ready1, rsp_v1, mis1, flt1, dw1, dr1;
  logic [31:0] rdata1, daddr1, dwd1, rd1;
  logic [3:0]  dsz1;
  logic        ready3, rsp_v3, mis3, flt3, dw3, dr3;
  logic [31:0] rdata3, daddr3, dwd3, rd3;
  logic [3:0]  dsz3;

  lsu_dmem_ctrl #(.MEM_ADDR_WIDTH(12), .DMEM_BASE(32'h0), .RD_LATENCY(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v1), .o_req_ready(ready1),
    .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_v1), .o_rsp_rdata(rdata1), .o_rsp_misalign(mis1), .o_rsp_fault(flt1),
    .o_data_addr(daddr1), .o_data_wr_data(dwd1), .o_data_size(dsz1), .o_data_write(dw1),
    .o_data_read(dr1), .i_data_rd_data(rd1)
  );

  lsu_dmem_ctrl #(.MEM_ADDR_WIDTH(12), .DMEM_BASE(32'h0), .RD_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v3), .o_req_ready(ready3),
    .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_v3), .o_rsp_rdata(rdata3), .o_rsp_misalign(mis3), .o_rsp_fault(flt3),
    .o_data_addr(daddr3), .o_data_wr_data(dwd3), .o_data_size(dsz3), .o_data_write(dw3),
    .o_data_read(dr3), .i_data_rd_data(rd3)
  );

  logic        ready, rsp_v, mis, flt, dw, dr;
  logic [31:0] rdata, daddr, dwd;
  logic [3:0]  dsz;
  assign ready = use3 ? ready3 : ready1;
  assign rsp_v = use3 ? rsp_v3 : rsp_v1;
  assign mis   = use3 ? mis3   : mis1;
  assign flt   = use3 ? flt3   : flt1;
  assign dw    = use3 ? dw3    : dw1;
  assign dr    = use3 ? dr3    : dr1;
  assign rdata = use3 ? rdata3 : rdata1;
  assign daddr = use3 ? daddr3 : daddr1;
  assign dwd   = use3 ? dwd3   : dwd1;
  assign dsz   = use3 ? dsz3   : dsz1;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A17_C3E5;
  endfunction

  // dmem environment: word array, synchronous read with 1- and 3-cycle pipes.
  // Outside the valid slot the read bus carries a poison value.
  logic [31:0] dmem [1024];
  logic        mem_load;
  logic        p1_v;
  logic [31:0] p1_w;
  logic [2:0]  p3_v;
  logic [31:0] p3_w [3];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= init_word(i);
    end else begin
      if (dw1) for (int k = 0; k < 4; k++) if (dsz1[k]) dmem[daddr1[11:2]][8*k +: 8] <= dwd1[8*k +: 8];
      if (dw3) for (int k = 0; k < 4; k++) if (dsz3[k]) dmem[daddr3[11:2]][8*k +: 8] <= dwd3[8*k +: 8];
    end
    p1_v    <= dr1;
    p1_w    <= dmem[daddr1[11:2]];
    p3_v    <= {p3_v[1:0], dr3};
    p3_w[0] <= dmem[daddr3[11:2]];
    p3_w[1] <= p3_w[0];
    p3_w[2] <= p3_w[1];
  end
  assign rd1 = p1_v    ? p1_w    : 32'hDEAD_BEEF;
  assign rd3 = p3_v[2] ? p3_w[2] : 32'hDEAD_BEEF;

  // Reference model: flat byte memory plus access rules.
  logic [7:0] ref_mem [WIN];
  int total = 0;
  int bad   = 0;

  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got);
    int sz, lat, lat_exp;
    bit mis_e, flt_e, err, stray;
    logic [3:0]  be_e;
    logic [31:0] wd_e, rd_e;
    longint val;
    sz    = acc_size(f3);
    mis_e = (sz > 1) && ((int'(addr[1:0]) % sz) != 0);
    flt_e = !mis_e && (sz == 0 || (we && f3[2]) || addr >= WIN);
    err   = mis_e || flt_e;
    be_e  = 4'b0000;
    wd_e  = 32'h0;
    rd_e  = 32'h0;
    if (!err && we) begin
      for (int k = 0; k < 4; k++) begin
        if (k >= int'(addr[1:0]) && k < int'(addr[1:0]) + sz) be_e[k] = 1'b1;
        wd_e[8*k +: 8] = wdata[8*(k % sz) +: 8];
      end
    end
    if (!err && !we) begin
      be_e = 4'b1111;
      val  = 0;
      for (int k = 0; k < sz; k++) val = val | (longint'(ref_mem[int'(addr[11:0]) + k]) << (8*k));
      if (!f3[2] && sz < 4 && val >= (longint'(1) << (8*sz - 1))) val = val - (longint'(1) << (8*sz));
      rd_e = val[31:0];
    end
    lat_exp = (err || we) ? 1 : (use3 ? 4 : 2);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    total++;
    if ({ready, dw, dr, dsz} !== {1'b1, !err && we, !err && !we, be_e}) begin
      bad++;
      $display("FAIL %s strobes: got rdy/w/r/size=%b/%b/%b/%b want %b/%b/%b/%b", tag,
               ready, dw, dr, dsz, 1'b1, !err && we, !err && !we, be_e);
    end
    if (!err) begin
      total++;
      if (daddr !== {addr[31:2], 2'b00}) begin
        bad++;
        $display("FAIL %s addr: got 0x%h want 0x%h", tag, daddr, {addr[31:2], 2'b00});
      end
    end
    if (!err && we) begin
      total++;
      if (dwd !== wd_e) begin
        bad++;
        $display("FAIL %s wr_data: got 0x%h want 0x%h", tag, dwd, wd_e);
      end
      for (int k = 0; k < 4; k++) if (be_e[k]) ref_mem[int'(addr[11:0]) - int'(addr[1:0]) + k] = wd_e[8*k +: 8];
    end
    @(posedge clk);

    lat = 0;
    stray = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0; req_we = $urandom_range(1); req_f3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
      #1;
      if (rsp_v) begin
        lat = c;
        break;
      end
      if (dw || dr || ready) stray = 1'b1;
    end
    got = rdata;
    total++;
    if (lat != lat_exp || stray) begin
      bad++;
      $display("FAIL %s latency: got %0d (stray=%0d) want %0d", tag, lat, stray, lat_exp);
    end
    total++;
    if ({rdata, mis, flt} !== {rd_e, mis_e, flt_e}) begin
      bad++;
      $display("FAIL %s rsp: got rdata=0x%h mis=%b flt=%b want rdata=0x%h mis=%b flt=%b",
               tag, rdata, mis, flt, rd_e, mis_e, flt_e);
    end
    @(negedge clk); #1;
    total++;
    if ({rsp_v, ready} !== 2'b01) begin
      bad++;
      $display("FAIL %s pulse end: got valid/ready=%b%b want 01", tag, rsp_v, ready);
    end
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    total++;
    if ({rsp_v1, rdata1, mis1, flt1, daddr1, dwd1, dsz1, dw1, dr1} !== '0 || ready1 !== 1'b1) begin
      bad++;
      $display("FAIL reset_lat1: got ready=%b rsp=%b size=%b w=%b r=%b want ready=1 others 0",
               ready1, rsp_v1, dsz1, dw1, dr1);
    end
    total++;
    if ({rsp_v3, rdata3, mis3, flt3, daddr3, dwd3, dsz3, dw3, dr3} !== '0 || ready3 !== 1'b1) begin
      bad++;
      $display("FAIL reset_lat3: got ready=%b rsp=%b size=%b w=%b r=%b want ready=1 others 0",
               ready3, rsp_v3, dsz3, dw3, dr3);
    end
  endtask

  task automatic test_store_byte;
    logic [31:0] g;
    use3 = 1'b0;
    run_req("sb_0x6", 1'b1, 3'b000, 32'h6, 32'hA5, g);
  endtask

  task automatic test_load_ext;
    logic [31:0] g;
    logic [31:0] exp_v [4];
    logic [2:0]  f3s   [4];
    logic [31:0] ads   [4];
    use3 = 1'b0;
    exp_v = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8000, 32'h8000_F0FF};
    f3s   = '{3'b000, 3'b100, 3'b001, 3'b010};
    ads   = '{32'h11, 32'h11, 32'h12, 32'h10};
    run_req("sw_0x10", 1'b1, 3'b010, 32'h10, 32'h8000_F0FF, g);
    for (int i = 0; i < 4; i++) begin
      run_req($sformatf("load%0d", i), 1'b0, f3s[i], ads[i], 32'h0, g);
      total++;
      if (g !== exp_v[i]) begin
        bad++;
        $display("FAIL load%0d_value: got 0x%h want 0x%h", i, g, exp_v[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] g;
    use3 = 1'b0;
    run_req("lw_mis",   1'b0, 3'b010, 32'h0000_0102, 32'h0, g);
    run_req("sh_mis",   1'b1, 3'b001, 32'h0000_0001, 32'h1234, g);
    run_req("sw_fault", 1'b1, 3'b010, 32'h0000_1000, 32'h5555_AAAA, g);
    run_req("lh_prio",  1'b0, 3'b001, 32'h0000_1001, 32'h0, g);
    run_req("ld_f3_3",  1'b0, 3'b011, 32'h0000_0040, 32'h0, g);
    run_req("sbu_ill",  1'b1, 3'b100, 32'h0000_0044, 32'hFF, g);
  endtask

  task automatic test_back_to_back;
    logic [31:0] g;
    int low;
    bit seen;
    use3 = 1'b1;
    run_req("sw_0x20", 1'b1, 3'b010, 32'h20, 32'h1234_5678, g);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h20;
    #1;
    total++;
    if ({ready, dr} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_lw_accept: got ready/read=%b%b want 11", ready, dr);
    end
    low = 0;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk); #1;
      if (!ready) low++;
      if (rsp_v) begin
        seen = 1'b1;
        total++;
        if (rdata !== 32'h1234_5678) begin
          bad++;
          $display("FAIL b2b_lw_data: got 0x%h want 0x12345678", rdata);
        end
        req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h24; req_wdata = 32'hCAFE_F00D;
      end
    end
    total++;
    if (!seen || low != 4) begin
      bad++;
      $display("FAIL b2b_ready_low: got %0d cycles (seen=%0d) want 4", low, seen);
    end
    @(negedge clk); #1;
    total++;
    if ({ready, dw, daddr, dsz, dwd} !== {1'b1, 1'b1, 32'h24, 4'b1111, 32'hCAFE_F00D}) begin
      bad++;
      $display("FAIL b2b_sw_accept: got ready=%b w=%b addr=0x%h size=%b data=0x%h want 1 1 0x24 1111 0xcafef00d",
               ready, dw, daddr, dsz, dwd);
    end
    for (int k = 0; k < 4; k++) ref_mem[32'h24 + k] = req_wdata[8*k +: 8];
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    total++;
    if ({rsp_v, rdata, mis, flt} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL b2b_sw_rsp: got valid=%b rdata=0x%h want valid=1 rdata=0", rsp_v, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit stray;
    use3 = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_v3, rdata3, mis3, flt3, dsz3, dw3, dr3} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got rsp=%b size=%b w=%b r=%b want all 0", rsp_v3, dsz3, dw3, dr3);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (rsp_v3 || !ready3) stray = 1'b1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL rst_mid_idle: got stray response or ready low want idle");
    end
  endtask

  task automatic test_random;
    logic [31:0] g, a;
    for (int i = 0; i < 300; i++) begin
      use3 = $urandom_range(3) == 0;
      a = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(WIN - 1));
      run_req($sformatf("rnd%0d", i), 1'($urandom_range(1)), 3'($urandom), a, $urandom, g);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; mem_load = 1'b1; req_valid = 1'b0; use3 = 1'b0;
    req_we = 1'b0; req_f3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      w = init_word(i);
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
    end
    repeat (3) @(posedge clk);
    test_reset();
    mem_load = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    test_store_byte();
    test_load_ext();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
